// File: rtl/pipe_scheduler.sv
`timescale 1ns/1ps
// pipe_scheduler: scrolling pipe field for a flappy-bird style game.
// Holds COLS columns of 15-bit pipe patterns, shifts them toward column 0
// on each scroll tick, inserts a new pattern every GAP ticks from a one-deep
// buffer fed by a request/valid handshake, detects collisions at BIRD_COL
// and keeps a saturating score.
// Optional feature: define PIPE_SCHED_BYPASS_EN to let a pattern arriving
// on the same cycle as a due insertion go straight into the last column.
module pipe_scheduler #(
  parameter int COLS     = 16,
  parameter int GAP      = 4,
  parameter int BIRD_COL = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    tick,
  input  logic [3:0]              bird_row,
  output logic                    pat_req,
  input  logic                    pat_valid,
  input  logic [14:0]             pat_data,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [14:0]             rd_data,
  output logic                    hit,
  output logic [7:0]              score,
  output logic [1:0]              state
);

  localparam int GW = $clog2(GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [14:0]     col_q [COLS];
  logic [14:0]     col_d [COLS];
  logic [14:0]     buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]      score_q, score_d;
  logic            hit_q, hit_d;

  logic            run;
  logic            collision;
  logic            xfer;
  logic            due;
  logic [14:0]     bird_col;
  logic [15:0]     bird_col_ext;
  logic [14:0]     insert_val;

  // Shared decode: game running, handshake transfer, insertion due, collision.
  // Row 15 maps onto a forced-1 bit so an off-screen bird always collides.
  always_comb begin
    run          = (state_q == S_RUN);
    bird_col     = col_q[BIRD_COL];
    bird_col_ext = {1'b1, bird_col};
    collision    = run && bird_col_ext[bird_row];
    xfer         = run && !buf_full_q && pat_valid;
    due          = (gap_cnt_q == GAP_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: start (re)enters RUN from anywhere, collision ends the run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (start)          state_d = S_RUN;
        else if (collision) state_d = S_OVER;
      end
      S_OVER:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request a pattern whenever running with an empty buffer.
  always_comb begin
    pat_req = (state_q == S_RUN) && !buf_full_q;
    state   = state_q;
    hit     = hit_q;
    score   = score_q;
  end

  // Datapath next state: clear on start, otherwise shift/insert/score in RUN.
  always_comb begin
    for (int i = 0; i < COLS; i++) col_d[i] = col_q[i];
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    gap_cnt_d  = gap_cnt_q;
    score_d    = score_q;
    hit_d      = hit_q;
    insert_val = '0;

    if (start) begin
      for (int i = 0; i < COLS; i++) col_d[i] = '0;
      buf_d      = '0;
      buf_full_d = 1'b0;
      gap_cnt_d  = GAP_LAST;
      score_d    = '0;
      hit_d      = 1'b0;
    end else if (run) begin
      if (collision) hit_d = 1'b1;
      if (xfer) begin
        buf_d      = pat_data;
        buf_full_d = 1'b1;
      end
      if (tick) begin
        if (due && buf_full_q) begin
          insert_val = buf_q;
          buf_full_d = 1'b0;
          gap_cnt_d  = '0;
        end
`ifdef PIPE_SCHED_BYPASS_EN
        // Pattern arriving exactly when insertion is due skips the buffer.
        else if (due && xfer) begin
          insert_val = pat_data;
          buf_full_d = 1'b0;
          gap_cnt_d  = '0;
        end
`endif
        else if (!due) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
        // With nothing to insert while due, gap_cnt holds so the next tick retries.
        for (int i = 0; i < COLS - 1; i++) col_d[i] = col_q[i+1];
        col_d[COLS-1] = insert_val;
        // A pipe counts as passed when it leaves the bird column cleanly.
        if ((bird_col != '0) && !collision && (score_q != 8'hFF))
          score_d = score_q + 8'd1;
      end
    end
  end

  // Column registers, one per display column.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) col_q[gi] <= '0;
        else        col_q[gi] <= col_d[gi];
      end
    end
  endgenerate

  // Buffer, gap counter, score and hit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      gap_cnt_q  <= '0;
      score_q    <= '0;
      hit_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      gap_cnt_q  <= gap_cnt_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
    end
  end

  // Combinational display read port; out-of-range columns read as blank.
  always_comb begin
    rd_data = '0;
    if (int'(rd_col) < COLS) rd_data = col_q[rd_col];
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
`timescale 1ns/1ps
// Directed testbench for pipe_scheduler with default parameters.
module tb_pipe_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        tick;
  logic [3:0]  bird_row;
  logic        pat_req;
  logic        pat_valid;
  logic [14:0] pat_data;
  logic [3:0]  rd_col;
  logic [14:0] rd_data;
  logic        hit;
  logic [7:0]  score;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  localparam logic [14:0] P1 = 15'h7C1F;
  localparam logic [14:0] P2 = 15'h0020;
  localparam logic [14:0] P3 = 15'h1234;

  pipe_scheduler #(.COLS(16), .GAP(4), .BIRD_COL(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tick     (tick),
    .bird_row (bird_row),
    .pat_req  (pat_req),
    .pat_valid(pat_valid),
    .pat_data (pat_data),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .hit      (hit),
    .score    (score),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s val=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_col(input string tag, input int c, input logic [14:0] exp);
    rd_col = 4'(c);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] acc;
    reset = 1'b0; start = 1'b0; tick = 1'b0; bird_row = 4'd7;
    pat_valid = 1'b0; pat_data = '0; rd_col = '0;
    repeat (3) step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_req",   32'(pat_req), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_hit",   32'(hit), 32'd0);
    chk_col("rst_col15", 15, 15'h0);
    reset = 1'b1;
    step();

    // IDLE ignores tick
    tick = 1'b1; step(); tick = 1'b0;
    check("idle_state", 32'(state), 32'd0);
    check("idle_req",   32'(pat_req), 32'd0);
    chk_col("idle_col15", 15, 15'h0);

    // Basic insertion with pat_valid held high
    start = 1'b1; step(); start = 1'b0;
    check("a_state", 32'(state), 32'd1);
    check("a_req",   32'(pat_req), 32'd1);
    pat_valid = 1'b1; pat_data = P1; step();
    check("a_req_fall", 32'(pat_req), 32'd0);
    tick = 1'b1; step();
    chk_col("a_t1_col15", 15, P1);
    check("a_t1_req", 32'(pat_req), 32'd1);
    step();
    check("a_t2_req", 32'(pat_req), 32'd0);
    chk_col("a_t2_col15", 15, 15'h0);
    step(); step(); tick = 1'b0;
    chk_col("a_t4_col12", 12, P1);
    chk_col("a_t4_col13", 13, 15'h0);
    chk_col("a_t4_col15", 15, 15'h0);
    pat_valid = 1'b0;

    // Starved buffer: insertion retried every tick
    start = 1'b1; step(); start = 1'b0;
    check("b_score", 32'(score), 32'd0);
    chk_col("b_clear12", 12, 15'h0);
    tick = 1'b1; repeat (6) step(); tick = 1'b0;
    chk_col("b_col15", 15, 15'h0);
    check("b_req", 32'(pat_req), 32'd1);
    pat_valid = 1'b1; pat_data = P2; step(); pat_valid = 1'b0;
    check("b_req_fall", 32'(pat_req), 32'd0);
    tick = 1'b1; step(); tick = 1'b0;
    chk_col("b_ins15", 15, P2);

    // Collision at bird column
    bird_row = 4'd5;
    tick = 1'b1; repeat (13) step(); tick = 1'b0;
    chk_col("c_col2", 2, P2);
    check("c_state_pre", 32'(state), 32'd1);
    check("c_hit_pre",   32'(hit), 32'd0);
    step();
    check("c_hit",   32'(hit), 32'd1);
    check("c_state", 32'(state), 32'd2);
    check("c_score", 32'(score), 32'd0);
    tick = 1'b1; pat_valid = 1'b1; repeat (3) step(); tick = 1'b0; pat_valid = 1'b0;
    chk_col("c_frz_col2", 2, P2);
    check("c_frz_score", 32'(score), 32'd0);
    check("c_frz_state", 32'(state), 32'd2);
    check("c_frz_hit",   32'(hit), 32'd1);
    check("c_frz_req",   32'(pat_req), 32'd0);

    // start + tick together from OVER
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    check("d_state", 32'(state), 32'd1);
    check("d_score", 32'(score), 32'd0);
    check("d_hit",   32'(hit), 32'd0);
    chk_col("d_col2",  2, 15'h0);
    chk_col("d_col15", 15, 15'h0);
    pat_valid = 1'b1; pat_data = P1; step(); pat_valid = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    chk_col("d_ins15", 15, P1);

    // Tick coincident with first transfer while insertion due
    start = 1'b1; step(); start = 1'b0;
    pat_valid = 1'b1; pat_data = P3; tick = 1'b1; step(); pat_valid = 1'b0; tick = 1'b0;
`ifdef PIPE_SCHED_BYPASS_EN
    chk_col("e_col15", 15, P3);
    check("e_req", 32'(pat_req), 32'd1);
    tick = 1'b1; step(); tick = 1'b0;
    chk_col("e2_col14", 14, P3);
    chk_col("e2_col15", 15, 15'h0);
`else
    chk_col("e_col15", 15, 15'h0);
    check("e_req", 32'(pat_req), 32'd0);
    tick = 1'b1; step(); tick = 1'b0;
    chk_col("e2_col15", 15, P3);
    chk_col("e2_col14", 14, 15'h0);
`endif

    // Score progress and saturation
    bird_row = 4'd7;
    start = 1'b1; step(); start = 1'b0;
    pat_valid = 1'b1; pat_data = P1; tick = 1'b1;
    repeat (40) step();
    check("f_score40", 32'(score), 32'd7);
    repeat (1360) step();
    tick = 1'b0; pat_valid = 1'b0;
    check("f_score_sat", 32'(score), 32'd255);
    check("f_hit",       32'(hit), 32'd0);
    check("f_state",     32'(state), 32'd1);

    // Off-screen bird collides
    start = 1'b1; step(); start = 1'b0;
    bird_row = 4'd15; step(); bird_row = 4'd7;
    check("g_hit",   32'(hit), 32'd1);
    check("g_state", 32'(state), 32'd2);

    // Asynchronous reset mid-game
    start = 1'b1; step(); start = 1'b0;
    pat_valid = 1'b1; pat_data = P1; tick = 1'b1;
    repeat (6) step();
    tick = 1'b0; pat_valid = 1'b0;
    check("h_pre_state", 32'(state), 32'd1);
    #1; reset = 1'b0; #1;
    check("h_state", 32'(state), 32'd0);
    check("h_req",   32'(pat_req), 32'd0);
    check("h_score", 32'(score), 32'd0);
    check("h_hit",   32'(hit), 32'd0);
    acc = '0;
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c);
      #1;
      acc = acc | rd_data;
    end
    check("h_cols_or", 32'(acc), 32'd0);
    step();
    reset = 1'b1;
    tick = 1'b1; pat_valid = 1'b1; step(); tick = 1'b0; pat_valid = 1'b0;
    check("h_idle_state", 32'(state), 32'd0);
    check("h_idle_req",   32'(pat_req), 32'd0);
    chk_col("h_idle_col15", 15, 15'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
